vscale_dmem_rr_scheduler: RTL and testbench

//  Round-robin scheduler that drives the data-memory arbiter's next_core select in multi-core vscale.

---
 rtl/vscale_dmem_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_vscale_dmem_rr_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_rr_scheduler.sv
// Round-robin owner scheduler for the multi-core vscale dmem arbiter.
// Watches per-core HASTI htrans/hmastlock and drives the arbiter's next_core
// select. An owner keeps the port for a bounded burst unless it holds a lock.
module vscale_dmem_rr_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_IDX_WIDTH = 2,
    parameter int MAX_HOLD       = 8,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [NUM_CORES*2-1:0]    core_htrans,
    input  logic [NUM_CORES-1:0]      core_hmastlock,
    input  logic                      dmem_hready,
    output logic [CORE_IDX_WIDTH-1:0] next_core,
    output logic                      grant_active,
    output logic [CNT_WIDTH-1:0]      hold_cnt
);

    localparam logic [CNT_WIDTH-1:0] MAX_HOLD_C    = CNT_WIDTH'(MAX_HOLD);
    localparam logic [CNT_WIDTH:0]   MAX_HOLD_WIDE = (CNT_WIDTH+1)'(MAX_HOLD);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                    state_q, state_d;
    logic [CORE_IDX_WIDTH-1:0] next_core_q, next_core_d;
    logic                      grant_active_q, grant_active_d;
    logic [CNT_WIDTH-1:0]      hold_cnt_q, hold_cnt_d;

    logic [NUM_CORES-1:0]      req;
    logic [1:0]                owner_htrans;
    logic                      owner_req;
    logic                      owner_lock;
    logic                      others_req;
    logic                      accepted;
    logic [CNT_WIDTH:0]        hold_sum;
    logic                      limit_hit;
    logic [CORE_IDX_WIDTH-1:0] scan_pick;

    // Decode requests and pick out the current owner's bus signals
    always_comb begin
        req          = '0;
        owner_htrans = 2'b00;
        owner_lock   = 1'b0;
        others_req   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            req[i] = (core_htrans[2*i +: 2] != 2'b00);
            if (next_core_q == CORE_IDX_WIDTH'(i)) begin
                owner_htrans = core_htrans[2*i +: 2];
                owner_lock   = core_hmastlock[i];
            end else if (core_htrans[2*i +: 2] != 2'b00) begin
                others_req = 1'b1;
            end
        end
        owner_req = (owner_htrans != 2'b00);
        accepted  = owner_htrans[1] && dmem_hready;
        hold_sum  = {1'b0, hold_cnt_q} + {{CNT_WIDTH{1'b0}}, accepted};
        limit_hit = (hold_sum >= MAX_HOLD_WIDE);
    end

    // Round-robin scan starting after the owner; iterating from the far end
    // lets the nearest requester overwrite, so the owner itself is checked last
    always_comb begin
        scan_pick = next_core_q;
        for (int unsigned k = NUM_CORES; k >= 1; k--) begin
            if (req[(32'(next_core_q) + k) % NUM_CORES]) begin
                scan_pick = CORE_IDX_WIDTH'((32'(next_core_q) + k) % NUM_CORES);
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        next_core_d    = next_core_q;
        grant_active_d = grant_active_q;
        hold_cnt_d     = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d        = ST_BUSY;
                    next_core_d    = scan_pick;
                    grant_active_d = 1'b1;
                    hold_cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                if (dmem_hready) begin
                    if (!owner_req || (limit_hit && others_req && !owner_lock)) begin
                        state_d        = ST_IDLE;
                        grant_active_d = 1'b0;
                        hold_cnt_d     = '0;
                    end else begin
                        hold_cnt_d = limit_hit ? MAX_HOLD_C : hold_sum[CNT_WIDTH-1:0];
                    end
                end
            end
        endcase
    end

    // State and output registers, asynchronous active-low reset
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q        <= ST_IDLE;
            next_core_q    <= '0;
            grant_active_q <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            next_core_q    <= next_core_d;
            grant_active_q <= grant_active_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign next_core    = next_core_q;
    assign grant_active = grant_active_q;
    assign hold_cnt     = hold_cnt_q;

endmodule

// File: tb/tb_vscale_dmem_rr_scheduler.sv
// Directed bench for vscale_dmem_rr_scheduler: expected outputs are queued
// when each step's inputs are driven and checked just after the clock edge.
module tb_vscale_dmem_rr_scheduler;

    typedef struct packed {
        logic [1:0] nc;
        logic       ga;
        logic [3:0] hc;
    } exp_t;

    logic       hclk;
    logic       hresetn;
    logic [7:0] core_htrans;
    logic [3:0] core_hmastlock;
    logic       dmem_hready;
    logic [1:0] next_core;
    logic       grant_active;
    logic [3:0] hold_cnt;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    vscale_dmem_rr_scheduler #(
        .NUM_CORES      (4),
        .CORE_IDX_WIDTH (2),
        .MAX_HOLD       (8),
        .CNT_WIDTH      (4)
    ) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .core_htrans    (core_htrans),
        .core_hmastlock (core_hmastlock),
        .dmem_hready    (dmem_hready),
        .next_core      (next_core),
        .grant_active   (grant_active),
        .hold_cnt       (hold_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int nc, input int ga, input int hc);
        exp_t e;
        e.nc = 2'(nc);
        e.ga = 1'(ga);
        e.hc = 4'(hc);
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        exp_t o;
        o = {next_core, grant_active, hold_cnt};
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got nc=%0d ga=%0d hc=%0d", tag, o.nc, o.ga, o.hc);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                tests_failed++;
                $error("FAIL %s: got nc=%0d ga=%0d hc=%0d, expected nc=%0d ga=%0d hc=%0d",
                       tag, o.nc, o.ga, o.hc, e.nc, e.ga, e.hc);
            end
        end
    endtask

    task automatic step(input logic [7:0] ht, input logic [3:0] lk, input logic rdy,
                        input int nc, input int ga, input int hc, input string tag);
        core_htrans    = ht;
        core_hmastlock = lk;
        dmem_hready    = rdy;
        push_exp(nc, ga, hc);
        @(posedge hclk);
        #1;
        compare(tag);
    endtask

    initial begin
        int owners[4];
        owners = '{1, 2, 3, 0};

        // Reset asserted from time zero with random inputs, checked before any edge
        hresetn        = 1'b0;
        core_htrans    = 8'($urandom);
        core_hmastlock = 4'($urandom);
        dmem_hready    = 1'($urandom);
        #2;
        push_exp(0, 0, 0);
        compare("rst_async_t0");
        step(8'($urandom), 4'($urandom), 1'b1, 0, 0, 0, "rst_held_edge");
        hresetn = 1'b1;

        // Single requester core2: one-cycle grant, three transfers, release
        step(8'h20, 4'h0, 1'b1, 2, 1, 0, "t2_grant");
        step(8'h20, 4'h0, 1'b1, 2, 1, 1, "t2_xfer1");
        step(8'h20, 4'h0, 1'b1, 2, 1, 2, "t2_xfer2");
        step(8'h20, 4'h0, 1'b1, 2, 1, 3, "t2_xfer3");
        step(8'h00, 4'h0, 1'b1, 2, 0, 0, "t2_release");
        step(8'h00, 4'h0, 1'b1, 2, 0, 0, "t2_idle_hold");

        // Core2 re-granted (checked last in scan), then async reset mid-tenure
        step(8'h20, 4'h0, 1'b1, 2, 1, 0, "t6_grant");
        for (int h = 1; h <= 4; h++) step(8'h20, 4'h0, 1'b1, 2, 1, h, "t6_xfer");
        hresetn = 1'b0;
        #1;
        push_exp(0, 0, 0);
        compare("t6_async_rst");
        step(8'hA0, 4'h0, 1'b1, 0, 0, 0, "t6_rst_hold");
        hresetn = 1'b1;
        step(8'hA0, 4'h0, 1'b1, 2, 1, 0, "t6_regrant");
        step(8'h00, 4'h0, 1'b1, 2, 0, 0, "t6_release");

        // Fresh reset before the fairness run
        hresetn = 1'b0;
        #1;
        push_exp(0, 0, 0);
        compare("rst_pulse");
        step(8'h00, 4'h0, 1'b1, 0, 0, 0, "rst_pulse_hold");
        hresetn = 1'b1;

        // All cores streaming: owners 1,2,3,0 each get 8 transfers and a bubble
        foreach (owners[t]) begin
            step(8'hAA, 4'h0, 1'b1, owners[t], 1, 0, "t3_grant");
            for (int h = 1; h <= 7; h++) step(8'hAA, 4'h0, 1'b1, owners[t], 1, h, "t3_xfer");
            step(8'hAA, 4'h0, 1'b1, owners[t], 0, 0, "t3_release");
        end

        // Fifth tenure (owner 1) with wait states at hold_cnt=5
        step(8'hAA, 4'h0, 1'b1, 1, 1, 0, "t3_grant5");
        for (int h = 1; h <= 5; h++) step(8'hAA, 4'h0, 1'b1, 1, 1, h, "t4_xfer");
        for (int w = 0; w < 3; w++) step(8'hAA, 4'h0, 1'b0, 1, 1, 5, "t4_wait");
        step(8'hAA, 4'h0, 1'b1, 1, 1, 6, "t4_xfer6");
        step(8'hAA, 4'h0, 1'b1, 1, 1, 7, "t4_xfer7");
        step(8'hAA, 4'h0, 1'b1, 1, 0, 0, "t4_release");

        // Locked owner 3 is never pre-empted; count saturates at 8
        step(8'h80, 4'h8, 1'b1, 3, 1, 0, "t5_grant");
        for (int i = 1; i <= 20; i++) step(8'hAA, 4'h8, 1'b1, 3, 1, (i < 8) ? i : 8, "t5_locked");
        step(8'hAA, 4'h0, 1'b1, 3, 0, 0, "t5_unlock_release");
        step(8'hAA, 4'h0, 1'b1, 0, 1, 0, "t5_wrap_owner0");

        // HASTI BUSY holds ownership without counting; wait state blocks release
        step(8'h01, 4'h0, 1'b1, 0, 1, 0, "busy_no_count1");
        step(8'h01, 4'h0, 1'b1, 0, 1, 0, "busy_no_count2");
        step(8'h03, 4'h0, 1'b1, 0, 1, 1, "seq_count");
        step(8'h00, 4'h0, 1'b0, 0, 1, 1, "no_release_wait");
        step(8'h00, 4'h0, 1'b1, 0, 0, 0, "release_idle");
        step(8'h00, 4'h0, 1'b1, 0, 0, 0, "idle_hold");

        // Lone owner saturates without pre-emption
        step(8'h02, 4'h0, 1'b1, 0, 1, 0, "solo_grant");
        for (int i = 1; i <= 10; i++) step(8'h02, 4'h0, 1'b1, 0, 1, (i < 8) ? i : 8, "solo_sat");
        step(8'h00, 4'h0, 1'b1, 0, 0, 0, "solo_release");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
